// File: rtl/mem_ws_if.sv
// CPU-side bus between the 6502 core and mem_ws: address/data/direction out,
// registered read data and the RDY wait-state handshake back.
interface mem_ws_if;
    logic [15:0] addr;
    logic [7:0]  dor;
    logic        rw;
    logic [7:0]  di;
    logic        rdy;

    // Handshake: the master holds addr/dor/rw stable while rdy=0; the access
    // completes on the rising edge where rdy=1, and a read's data appears on
    // di from the following cycle until the next read completes.
    modport master (output addr, dor, rw, input di, rdy);
    modport slave  (input addr, dor, rw, output di, rdy);
endinterface

// File: rtl/mem_ws.sv
// 64 KiB memory for the 6502 bus with a wait-state region, a write-protected
// ROM window and a trap address that ends simulation with an exit code.
module mem_ws #(
  parameter string       MEM_FILE    = "",
  parameter logic [7:0]  INIT_VAL    = 8'hEA,
  parameter logic [15:0] SLOW_BASE   = 16'hC000,
  parameter logic [15:0] SLOW_MASK   = 16'hF000,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [15:0] ROM_BASE    = 16'hE000,
  parameter logic [15:0] TRAP_ADDR   = 16'hFFF0
) (
  input  logic       clk,
  input  logic       rst,
  mem_ws_if.slave    bus,
  output logic       done,
  output logic [7:0] exit_code,
  output logic       wp_err,
  output logic       dbg_state,
  output logic [3:0] dbg_cnt
);
  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [7:0]  di_q;
  logic        slow;
  logic        is_rom;
  logic        is_trap;
  logic        rdy;
  logic [7:0]  mem [0:65535];

  // Contents are initialised once at time zero and survive reset.
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = INIT_VAL;
  end

  assign slow    = ((bus.addr & SLOW_MASK) == SLOW_BASE) && (WAIT_CYCLES != 0);
  assign is_rom  = (bus.addr >= ROM_BASE);
  assign is_trap = (bus.addr == TRAP_ADDR);
  assign rdy     = (state == S_IDLE) ? !slow : (cnt == 4'd0);

  assign bus.rdy   = rdy;
  assign bus.di    = di_q;
  assign dbg_state = state;
  assign dbg_cnt   = cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      di_q      <= 8'h00;
      done      <= 1'b0;
      exit_code <= 8'h00;
      wp_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (slow) begin
          state <= S_WAIT;
          cnt   <= WAIT_LOAD;
        end
        S_WAIT: if (cnt != 4'd0) cnt <= cnt - 4'd1;
                else             state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (rdy) begin
        if (bus.rw) begin
          di_q <= mem[bus.addr];
        end else if (is_trap) begin
          // Trap sits inside ROM by default; it wins and is not a protection error.
          done <= 1'b1;
          if (!done) exit_code <= bus.dor;
        end else if (is_rom) begin
          wp_err <= 1'b1;
        end
      end
    end
  end

  // Gated by rst so a write pending when reset arrives never lands.
  always_ff @(posedge clk) begin
    if (!rst && rdy && !bus.rw && !is_trap && !is_rom)
      mem[bus.addr] <= bus.dor;
  end
endmodule

// File: tb/tb_mem_ws.sv
// Directed bench for mem_ws: fast/slow timing, ROM protection, trap, reset
// during a wait, and a zero-wait-state build.
module tb_mem_ws;
    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_ws_if b0 ();
    mem_ws_if b1 ();

    logic       done0, wp0, st0;
    logic [7:0] exit0;
    logic [3:0] cnt0;
    logic       done1, wp1, st1;
    logic [7:0] exit1;
    logic [3:0] cnt1;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    mem_ws #(.WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .bus(b0), .done(done0), .exit_code(exit0),
        .wp_err(wp0), .dbg_state(st0), .dbg_cnt(cnt0)
    );

    mem_ws #(.WAIT_CYCLES(0)) dut_nw (
        .clk(clk), .rst(rst), .bus(b1), .done(done1), .exit_code(exit1),
        .wp_err(wp1), .dbg_state(st1), .dbg_cnt(cnt1)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // Drives one access on b0 and returns after its completion edge.
    // trace collects rdy as sampled in each cycle, oldest in the MSB.
    task automatic access(input logic [15:0] a, input logic r, input logic [7:0] d,
                          output int cyc, output logic [7:0] trace);
        logic fin;
        @(negedge clk);
        b0.addr = a; b0.rw = r; b0.dor = d;
        cyc = 0; fin = 1'b0; trace = 8'h00;
        for (int i = 0; i < 20 && !fin; i++) begin
            #1;
            cyc++;
            fin = b0.rdy;
            trace = {trace[6:0], fin};
            @(posedge clk);
            if (!fin) @(negedge clk);
        end
        check("access_completed", {15'd0, fin}, 16'd1);
        #1;
        b0.addr = 16'h0000; b0.rw = 1'b1; b0.dor = 8'h00;
    endtask

    task automatic read_chk(input string tag, input logic [15:0] a, input logic [7:0] exp);
        int cyc;
        logic [7:0] tr;
        access(a, 1'b1, 8'h00, cyc, tr);
        @(negedge clk);
        check(tag, {8'h00, b0.di}, {8'h00, exp});
    endtask

    initial begin
        int cyc;
        logic [7:0] tr;

        b0.addr = 16'h0000; b0.rw = 1'b1; b0.dor = 8'h00;
        b1.addr = 16'h0000; b1.rw = 1'b1; b1.dor = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_di", {8'h00, b0.di}, 16'h0000);
        check("rst_done", {15'd0, done0}, 16'd0);
        check("rst_exit", {8'h00, exit0}, 16'h0000);
        check("rst_wp", {15'd0, wp0}, 16'd0);
        check("rst_state", {15'd0, st0}, 16'd0);
        check("rst_cnt", {12'd0, cnt0}, 16'd0);
        rst = 1'b0;

        // Fast region: one-cycle access, data the cycle after.
        access(16'h0200, 1'b0, 8'h5A, cyc, tr);
        check("fast_wr_cycles", 16'(cyc), 16'd1);
        access(16'h0200, 1'b1, 8'h00, cyc, tr);
        check("fast_rd_cycles", 16'(cyc), 16'd1);
        @(negedge clk);
        check("fast_rd_di", {8'h00, b0.di}, 16'h005A);

        // Slow region: rdy 0,0,1 then data.
        access(16'hC010, 1'b0, 8'h33, cyc, tr);
        check("slow_wr_cycles", 16'(cyc), 16'd3);
        access(16'hC010, 1'b1, 8'h00, cyc, tr);
        check("slow_rd_cycles", 16'(cyc), 16'd3);
        check("slow_rd_rdy_trace", {8'h00, tr}, 16'h0001);
        @(negedge clk);
        check("slow_rd_di", {8'h00, b0.di}, 16'h0033);
        access(16'hC010, 1'b0, 8'h77, cyc, tr);
        read_chk("slow_readback", 16'hC010, 8'h77);

        // ROM protection.
        access(16'hE000, 1'b0, 8'h11, cyc, tr);
        @(negedge clk);
        check("rom_wp_err", {15'd0, wp0}, 16'd1);
        check("rom_done", {15'd0, done0}, 16'd0);
        read_chk("rom_readback", 16'hE000, 8'hEA);
        read_chk("rom_ffff", 16'hFFFF, 8'hEA);

        // Reset while a slow write waits with cnt=1.
        @(negedge clk);
        b0.addr = 16'hC020; b0.rw = 1'b0; b0.dor = 8'h55;
        @(posedge clk);
        #1;
        check("wait_state", {15'd0, st0}, 16'd1);
        check("wait_cnt", {12'd0, cnt0}, 16'd1);
        rst = 1'b1;
        #1;
        check("abort_state", {15'd0, st0}, 16'd0);
        check("abort_cnt", {12'd0, cnt0}, 16'd0);
        check("abort_di", {8'h00, b0.di}, 16'h0000);
        check("abort_wp", {15'd0, wp0}, 16'd0);
        check("abort_done", {15'd0, done0}, 16'd0);
        check("abort_exit", {8'h00, exit0}, 16'h0000);
        @(negedge clk);
        b0.addr = 16'h0000; b0.rw = 1'b1; b0.dor = 8'h00;
        rst = 1'b0;
        read_chk("abort_readback", 16'hC020, 8'hEA);

        // Trap: first code wins, no protection error.
        access(16'hFFF0, 1'b0, 8'h42, cyc, tr);
        @(negedge clk);
        check("trap_done", {15'd0, done0}, 16'd1);
        check("trap_exit", {8'h00, exit0}, 16'h0042);
        check("trap_wp", {15'd0, wp0}, 16'd0);
        access(16'hFFF0, 1'b0, 8'h99, cyc, tr);
        @(negedge clk);
        check("trap2_exit", {8'h00, exit0}, 16'h0042);
        check("trap2_done", {15'd0, done0}, 16'd1);
        check("trap2_wp", {15'd0, wp0}, 16'd0);
        read_chk("trap_read", 16'hFFF0, 8'hEA);

        // Zero-wait build: slow region is as fast as RAM.
        @(negedge clk);
        b1.addr = 16'h0000; b1.rw = 1'b0; b1.dor = 8'h12;
        @(negedge clk);
        b1.addr = 16'hC000; b1.rw = 1'b0; b1.dor = 8'h34;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i > 0) check("nw_di", {8'h00, b1.di}, {8'h00, exp_q.pop_front()});
            b1.addr = (i % 2 == 1) ? 16'hC000 : 16'h0000;
            b1.rw   = 1'b1;
            #1;
            check("nw_rdy", {15'd0, b1.rdy}, 16'd1);
            exp_q.push_back((i % 2 == 1) ? 8'h34 : 8'h12);
        end
        @(negedge clk);
        check("nw_di_last", {8'h00, b1.di}, {8'h00, exp_q.pop_front()});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
